// File: rtl/bin_to_e3_converter.sv
// Sequential binary-to-Excess-3 converter (shift-and-add-3, one bit per cycle).
// Saturates to all-9s with ovf=1 when the operand exceeds the digit range.
module bin_to_e3_converter #(
    parameter int W_BIN = 8,
    parameter int N_DIG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W_BIN-1:0]     bin_in,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [4*N_DIG-1:0]   e3_number
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int CMP_W = (W_BIN > BCD_W + 1) ? W_BIN : BCD_W + 1;
    localparam int CNT_W = $clog2(W_BIN + 1);

    function automatic logic [CMP_W-1:0] pow10(input int n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < n; i++) begin
            p = p * CMP_W'(10);
        end
        return p;
    endfunction

    localparam logic [CMP_W-1:0] DEC_LIMIT = pow10(N_DIG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_r;
    logic [W_BIN-1:0]     shift_r;
    logic [BCD_W-1:0]     bcd_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 ovf_pend_r;

    logic [CMP_W-1:0]     bin_ext_s;
    logic [BCD_W-1:0]     bcd_adj_s;
    logic [BCD_W-1:0]     bcd_shift_s;
    logic [BCD_W-1:0]     e3_next_s;

    // Next BCD value for one iteration and Excess-3 view of the finished accumulator
    always_comb begin
        bin_ext_s              = '0;
        bin_ext_s[W_BIN-1:0]   = bin_in;
        bcd_adj_s              = '0;
        e3_next_s              = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
            e3_next_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
        // Top bit of the accumulator falls off; overflow is already flagged at load
        bcd_shift_s = {bcd_adj_s[BCD_W-2:0], shift_r[W_BIN-1]};
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            e3_number  <= {N_DIG{4'h3}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r    <= bin_in;
                        bcd_r      <= '0;
                        cnt_r      <= CNT_W'(W_BIN);
                        ovf_pend_r <= (bin_ext_s >= DEC_LIMIT);
                        busy       <= 1'b1;
                        state_r    <= CONV;
                    end else begin
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                CONV: begin
                    bcd_r   <= bcd_shift_s;
                    shift_r <= shift_r << 1'b1;
                    cnt_r   <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= FINISH;
                    end else begin
                        state_r <= CONV;
                    end
                end
                FINISH: begin
                    if (ovf_pend_r) begin
                        e3_number <= {N_DIG{4'hC}};
                        ovf       <= 1'b1;
                    end else begin
                        e3_number <= e3_next_s;
                        ovf       <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_e3_converter.sv
// Self-checking bench: a 3-digit and a 2-digit converter checked against a decimal
// arithmetic reference model with directed and $urandom operands.
module tb_bin_to_e3_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start3, start2;
    logic [7:0]  bin3, bin2;
    logic        busy3, done3, ovf3;
    logic        busy2, done2, ovf2;
    logic [11:0] e3_3;
    logic [7:0]  e3_2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_e3_converter #(.W_BIN(8), .N_DIG(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
        .busy(busy3), .done(done3), .ovf(ovf3), .e3_number(e3_3)
    );

    bin_to_e3_converter #(.W_BIN(8), .N_DIG(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
        .busy(busy2), .done(done2), .ovf(ovf2), .e3_number(e3_2)
    );

    function automatic logic [11:0] ref_e3(input int v, input int nd);
        logic [11:0] r;
        int lim, p;
        r = 12'h000;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (v >= lim) r[4*i +: 4] = 4'hC;
            else          r[4*i +: 4] = 4'((v / p) % 10 + 3);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int nd);
        int lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    // Drive one conversion from idle and wait (bounded) for done; no checking here.
    task automatic conv(input int sel, input int v, output logic [11:0] e3,
                        output logic ov, output int lat);
        @(negedge clk);
        if (sel == 3) begin bin3 = 8'(v); start3 = 1'b1; end
        else          begin bin2 = 8'(v); start2 = 1'b1; end
        @(negedge clk);
        start3 = 1'b0; start2 = 1'b0;
        bin3 = 8'($urandom); bin2 = 8'($urandom);
        lat = 0;
        while (!((sel == 3) ? done3 : done2) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e3 = (sel == 3) ? e3_3 : {4'h0, e3_2};
        ov = (sel == 3) ? ovf3 : ovf2;
    endtask

    task automatic test_reset();
        rst = 1'b1; start3 = 1'b0; start2 = 1'b0; bin3 = 8'd0; bin2 = 8'd0;
        repeat (2) @(negedge clk);
        checks++; if (e3_3 !== 12'h333) begin failures++; $display("FAIL reset_e3 got=%h exp=333", e3_3); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done3); end
        checks++; if (ovf3 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf3); end
        checks++; if (e3_2 !== 8'h33 || busy2 !== 1'b0 || ovf2 !== 1'b0) begin
            failures++; $display("FAIL reset_dut2 got=%h/%b/%b exp=33/0/0", e3_2, busy2, ovf2); end
        rst = 1'b0;
    endtask

    task automatic test_zero_latency();
        int busy_cnt, done_k, ndone;
        busy_cnt = 0; done_k = -1; ndone = 0;
        @(negedge clk); bin3 = 8'd0; start3 = 1'b1;
        @(negedge clk); start3 = 1'b0; bin3 = 8'($urandom);
        for (int k = 0; k < 15; k++) begin
            if (busy3) busy_cnt++;
            if (done3) begin
                if (done_k < 0) done_k = k;
                ndone++;
            end
            @(negedge clk);
        end
        checks++; if (busy_cnt != 9) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=9", busy_cnt); end
        checks++; if (done_k != 9) begin failures++; $display("FAIL zero_done_latency got=%0d exp=9", done_k); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", ndone); end
        checks++; if (e3_3 !== 12'h333 || ovf3 !== 1'b0) begin
            failures++; $display("FAIL zero_result got=%h/%b exp=333/0", e3_3, ovf3); end
    endtask

    task automatic test_vectors();
        int vals[$];
        logic [11:0] e3;
        logic ov;
        int lat;
        vals = '{255, 137, 9};
        for (int i = 0; i < 20; i++) vals.push_back(int'($urandom_range(0, 255)));
        foreach (vals[i]) begin
            conv(3, vals[i], e3, ov, lat);
            checks++; if (lat != 9) begin failures++; $display("FAIL vec_latency v=%0d got=%0d exp=9", vals[i], lat); end
            checks++; if (e3 !== ref_e3(vals[i], 3)) begin
                failures++; $display("FAIL vec_e3 v=%0d got=%h exp=%h", vals[i], e3, ref_e3(vals[i], 3)); end
            checks++; if (ov !== ref_ovf(vals[i], 3)) begin
                failures++; $display("FAIL vec_ovf v=%0d got=%b exp=%b", vals[i], ov, ref_ovf(vals[i], 3)); end
        end
    endtask

    task automatic test_two_digit();
        int vals[$];
        logic [11:0] e3, exp_full;
        logic [7:0]  exp8;
        logic ov;
        int lat;
        vals = '{99, 100, 255, 42};
        for (int i = 0; i < 10; i++) vals.push_back(int'($urandom_range(0, 255)));
        foreach (vals[i]) begin
            conv(2, vals[i], e3, ov, lat);
            exp_full = ref_e3(vals[i], 2);
            exp8 = exp_full[7:0];
            checks++; if (e3[7:0] !== exp8) begin
                failures++; $display("FAIL dig2_e3 v=%0d got=%h exp=%h", vals[i], e3[7:0], exp8); end
            checks++; if (ov !== ref_ovf(vals[i], 2)) begin
                failures++; $display("FAIL dig2_ovf v=%0d got=%b exp=%b", vals[i], ov, ref_ovf(vals[i], 2)); end
        end
    endtask

    task automatic test_ignore_mid_conv();
        logic [11:0] e3, got;
        logic ov;
        int lat, ndone;
        conv(3, 58, e3, ov, lat);
        @(negedge clk); bin3 = 8'd137; start3 = 1'b1;
        @(negedge clk); start3 = 1'b0; bin3 = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++; if (e3_3 !== ref_e3(58, 3) || busy3 !== 1'b1) begin
            failures++; $display("FAIL midconv_hold got=%h/%b exp=%h/1", e3_3, busy3, ref_e3(58, 3)); end
        bin3 = 8'd200; start3 = 1'b1;
        @(negedge clk); start3 = 1'b0; bin3 = 8'($urandom);
        ndone = 0; got = 12'h000;
        for (int j = 0; j < 25; j++) begin
            if (done3) begin ndone++; got = e3_3; end
            @(negedge clk);
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d exp=1", ndone); end
        checks++; if (got !== 12'h46A) begin failures++; $display("FAIL ignore_result got=%h exp=46A", got); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL ignore_idle_busy got=%b exp=0", busy3); end
    endtask

    task automatic test_start_held();
        int last, cnt;
        last = -1; cnt = 0;
        @(negedge clk); bin3 = 8'd77; start3 = 1'b1;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (done3) begin
                if (last >= 0) begin
                    checks++; if (j - last != 10) begin
                        failures++; $display("FAIL held_period got=%0d exp=10", j - last); end
                end
                checks++; if (e3_3 !== ref_e3(77, 3)) begin
                    failures++; $display("FAIL held_e3 got=%h exp=%h", e3_3, ref_e3(77, 3)); end
                last = j;
                cnt++;
            end
        end
        checks++; if (cnt != 4) begin failures++; $display("FAIL held_count got=%0d exp=4", cnt); end
        start3 = 1'b0;
        for (int j = 0; j < 20 && busy3; j++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_conv();
        logic [11:0] e3;
        logic ov;
        int lat, ndone;
        conv(2, 255, e3, ov, lat);
        checks++; if (e3[7:0] !== 8'hCC || ov !== 1'b1) begin
            failures++; $display("FAIL presat got=%h/%b exp=CC/1", e3[7:0], ov); end
        @(negedge clk); bin2 = 8'd42; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (e3_2 !== 8'h33 || ovf2 !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs got=%h/%b exp=33/0", e3_2, ovf2); end
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got=%b/%b exp=0/0", busy2, done2); end
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            if (done2 || busy2) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        conv(2, 42, e3, ov, lat);
        checks++; if (e3[7:0] !== 8'h75 || ov !== 1'b0) begin
            failures++; $display("FAIL after_rst_42 got=%h/%b exp=75/0", e3[7:0], ov); end
    endtask

    task automatic test_exhaustive_b2b();
        int lat;
        @(negedge clk); bin3 = 8'd0; start3 = 1'b1;
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            start3 = 1'b0; bin3 = 8'($urandom);
            checks++; if (done3 !== 1'b0 || busy3 !== 1'b1) begin
                failures++; $display("FAIL b2b_accept v=%0d done=%b busy=%b exp=0/1", v, done3, busy3); end
            lat = 0;
            while (!done3 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat != 9) begin failures++; $display("FAIL b2b_latency v=%0d got=%0d exp=9", v, lat); end
            checks++; if (e3_3 !== ref_e3(v, 3)) begin
                failures++; $display("FAIL b2b_e3 v=%0d got=%h exp=%h", v, e3_3, ref_e3(v, 3)); end
            checks++; if (ovf3 !== 1'b0) begin failures++; $display("FAIL b2b_ovf v=%0d got=%b exp=0", v, ovf3); end
            if (v < 255) begin
                bin3 = 8'(v + 1);
                start3 = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_vectors();
        test_two_digit();
        test_ignore_mid_conv();
        test_start_held();
        test_reset_mid_conv();
        test_exhaustive_b2b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
